// File: rtl/fifo_uart_tx_if.sv
// Handshake bundle between the SBUF FIFO read port, the UART transmitter and the serial pin.
// The master modport is the transmitter; the slave modport is the FIFO/pin side.
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  tx_en;
  logic                  fifo_empty;
  logic                  fifo_r_en;
  logic [DATA_WIDTH-1:0] fifo_r_data;
  logic                  txd;
  logic                  busy;
  logic                  tx_done;

  modport master (
    input  tx_en, fifo_empty, fifo_r_data,
    output fifo_r_en, txd, busy, tx_done
  );

  modport slave (
    output tx_en, fifo_empty, fifo_r_data,
    input  fifo_r_en, txd, busy, tx_done
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining the SBUF FIFO: start bit 2 cycles after the pop, (2+DATA_WIDTH)*BAUD_DIV cycles per frame,
// new frames only while tx_en=1 and the FIFO is non-empty. Define FIFO_UART_TX_PARITY_EN to append an even-parity bit.
module fifo_uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_DIV   = 104,
  parameter int DIV_WIDTH  = 16
) (
  input  logic           clk,
  input  logic           rst,
  fifo_uart_tx_if.master bus
);
  localparam int                   BIT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [DIV_WIDTH-1:0] BAUD_LAST = DIV_WIDTH'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0]     BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY = 3'd5,
`endif
    STOP   = 3'd6
  } state_t;

  state_t                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic                   txd_q, txd_d;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                   par_q, par_d;
`endif

  logic                   baud_last;
  logic [DIV_WIDTH-1:0]   baud_inc;

  assign baud_last = (baud_q == BAUD_LAST);
  assign baud_inc  = baud_last ? '0 : baud_q + DIV_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef FIFO_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.tx_en && !bus.fifo_empty) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        shift_d = bus.fifo_r_data;
        baud_d  = '0;
`ifdef FIFO_UART_TX_PARITY_EN
        par_d   = ^bus.fifo_r_data;
`endif
        state_d = START;
      end
      START: begin
        baud_d = baud_inc;
        if (baud_last) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        baud_d = baud_inc;
        if (baud_last) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        baud_d = baud_inc;
        if (baud_last) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        baud_d = baud_inc;
        if (baud_last) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // txd is registered from the next-state view so the pin changes together with the state.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY:  txd_d = par_d;
`endif
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.fifo_r_en = (state_q == FETCH);
  assign bus.busy      = (state_q != IDLE);
  assign bus.tx_done   = (state_q == STOP) && baud_last;
  assign bus.txd       = txd_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: instances at BAUD_DIV 4 and 2, a frame-level model compared every cycle,
// and directed literal checks on waveforms, gaps, gating and asynchronous reset.
module tb_fifo_uart_tx;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int          NSLOT  = 11;
  localparam logic [10:0] PAT_A5 = 11'h54A;
  localparam logic [10:0] PAT_07 = 11'h60E;
  localparam logic [10:0] PAT_3C = 11'h478;
`else
  localparam int          NSLOT  = 10;
  localparam logic [10:0] PAT_A5 = 11'h34A;
  localparam logic [10:0] PAT_07 = 11'h20E;
  localparam logic [10:0] PAT_3C = 11'h278;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_uart_tx_if #(.DATA_WIDTH(8)) bus0 ();
  fifo_uart_tx_if #(.DATA_WIDTH(8)) bus1 ();

  fifo_uart_tx #(.DATA_WIDTH(8), .BAUD_DIV(4), .DIV_WIDTH(16)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  fifo_uart_tx #(.DATA_WIDTH(8), .BAUD_DIV(2), .DIV_WIDTH(16)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] fq0[$];
  logic [7:0] fq1[$];
  logic       push_vld0, push_vld1;
  logic [7:0] push_dat0, push_dat1;

  int         m_act [2];
  int         m_c   [2];
  logic [7:0] m_byte[2];

  // Expected {txd, fifo_r_en, busy, tx_done} for cycle c counted from the FETCH cycle.
  function automatic logic [3:0] frame_exp(input int c, input int b_div, input logic [7:0] b);
    int   k;
    int   s;
    logic t;
    if (c == 0) return 4'b1110;
    if (c == 1) return 4'b1010;
    k = c - 2;
    s = k / b_div;
    if (s == 0)                        t = 1'b0;
    else if (s <= 8)                   t = b[s-1];
    else if (NSLOT == 11 && s == 9)    t = ^b;
    else                               t = 1'b1;
    return {t, 1'b0, 1'b1, (k == NSLOT * b_div - 1)};
  endfunction

  task automatic model_check(input int d, input logic [3:0] got);
    logic [3:0] want;
    want = 4'b1000;
    if (!rst && m_act[d] != 0) want = frame_exp(m_c[d], (d == 0) ? 4 : 2, m_byte[d]);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL model_dut%0d cycle %0d txd/ren/busy/done got %b want %b", d, cyc, got, want);
    end
  endtask

  task automatic model_advance(input int d, input logic en, input logic empty, input logic [7:0] front);
    if (rst) begin
      m_act[d] = 0;
    end else if (m_act[d] != 0) begin
      m_c[d]++;
      if (m_c[d] == NSLOT * ((d == 0) ? 4 : 2) + 2) m_act[d] = 0;
    end else if (en && !empty) begin
      m_act[d]  = 1;
      m_c[d]    = 0;
      m_byte[d] = front;
    end
  endtask

  // Single compare process; also plays the FIFO read port for both instances.
  initial begin
    m_act[0] = 0; m_act[1] = 0; m_c[0] = 0; m_c[1] = 0;
    m_byte[0] = 8'h00; m_byte[1] = 8'h00;
    bus0.fifo_empty = 1'b1; bus0.fifo_r_data = 8'h00;
    bus1.fifo_empty = 1'b1; bus1.fifo_r_data = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      model_check(0, {bus0.txd, bus0.fifo_r_en, bus0.busy, bus0.tx_done});
      model_check(1, {bus1.txd, bus1.fifo_r_en, bus1.busy, bus1.tx_done});
      if (push_vld0) fq0.push_back(push_dat0);
      if (push_vld1) fq1.push_back(push_dat1);
      if (bus0.fifo_r_en && fq0.size() > 0) bus0.fifo_r_data = fq0.pop_front();
      if (bus1.fifo_r_en && fq1.size() > 0) bus1.fifo_r_data = fq1.pop_front();
      bus0.fifo_empty = (fq0.size() == 0);
      bus1.fifo_empty = (fq1.size() == 0);
      model_advance(0, bus0.tx_en, bus0.fifo_empty, (fq0.size() > 0) ? fq0[0] : 8'h00);
      model_advance(1, bus1.tx_en, bus1.fifo_empty, (fq1.size() > 0) ? fq1[0] : 8'h00);
    end
  end

  function automatic logic get_txd(input int d);
    return (d == 0) ? bus0.txd : bus1.txd;
  endfunction
  function automatic logic get_ren(input int d);
    return (d == 0) ? bus0.fifo_r_en : bus1.fifo_r_en;
  endfunction
  function automatic logic get_done(input int d);
    return (d == 0) ? bus0.tx_done : bus1.tx_done;
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int d, input logic [7:0] b);
    if (d == 0) begin push_vld0 = 1'b1; push_dat0 = b; end
    else        begin push_vld1 = 1'b1; push_dat1 = b; end
    tick();
    push_vld0 = 1'b0;
    push_vld1 = 1'b0;
  endtask

  task automatic wait_ren(input int d, input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!get_ren(d) && n < 400);
    chk({nm, "_ren_seen"}, int'(get_ren(d)), 1);
  endtask

  // Called on the negedge of the FETCH cycle; records the whole frame and checks it against a literal pattern.
  task automatic capture(input int d, input int b_div, input logic [10:0] pat, input string nm);
    logic wv [0:99];
    int   fl, done_at, done_n, ren_n, zero_at;
    logic lvl;
    fl = NSLOT * b_div;
    done_at = -1; done_n = 0; ren_n = 0; zero_at = -1;
    for (int i = 1; i <= fl + 1; i++) begin
      @(negedge clk);
      wv[i] = get_txd(d);
      if (get_done(d)) begin
        done_n++;
        if (done_at < 0) done_at = i;
      end
      if (get_ren(d)) ren_n++;
      if (!wv[i] && zero_at < 0) zero_at = i;
    end
    chk({nm, "_load_txd"}, int'(wv[1]), 1);
    chk({nm, "_ren_to_start"}, zero_at, 2);
    for (int s = 0; s < NSLOT; s++) begin
      lvl = pat[s];
      for (int j = 0; j < b_div; j++) begin
        if (wv[2 + s * b_div + j] !== pat[s]) lvl = wv[2 + s * b_div + j];
      end
      chk($sformatf("%s_slot%0d", nm, s), int'(lvl), int'(pat[s]));
    end
    chk({nm, "_done_cycle"}, done_at, fl + 1);
    chk({nm, "_done_count"}, done_n, 1);
    chk({nm, "_extra_ren"}, ren_n, 0);
  endtask

  initial begin
    int n, ren_n, done_n, gap, ones, bad;
    rst = 1'b1;
    bus0.tx_en = 1'b0; bus1.tx_en = 1'b0;
    push_vld0 = 1'b0; push_vld1 = 1'b0; push_dat0 = 8'h00; push_dat1 = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_txd", int'(bus0.txd), 1);
    chk("reset_busy", int'(bus0.busy), 0);
    chk("reset_ren", int'(bus0.fifo_r_en), 0);
    tick();
    rst = 1'b0;

    // Single bytes 0xA5 then 0x07 at BAUD_DIV=4
    tick();
    push(0, 8'hA5);
    bus0.tx_en = 1'b1;
    wait_ren(0, "a5");
    capture(0, 4, PAT_A5, "a5");
    tick();
    bus0.tx_en = 1'b0;
    push(0, 8'h07);
    bus0.tx_en = 1'b1;
    wait_ren(0, "b07");
    capture(0, 4, PAT_07, "b07");
    repeat (3) @(negedge clk);
    chk("single_idle_busy", int'(bus0.busy), 0);

    // Back-to-back 0x00, 0xFF
    tick();
    bus0.tx_en = 1'b0;
    push(0, 8'h00);
    push(0, 8'hFF);
    bus0.tx_en = 1'b1;
    wait_ren(0, "b2b");
    n = 0; ren_n = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus0.fifo_r_en) ren_n++;
    end while (!bus0.tx_done && n < 200);
    chk("b2b_first_done", int'(bus0.tx_done), 1);
    gap = 0;
    do begin
      @(negedge clk);
      if (bus0.fifo_r_en) ren_n++;
      if (bus0.txd) gap++;
    end while (bus0.txd && gap < 50);
    chk("b2b_gap", gap, 3);
    chk("b2b_ren_count", ren_n, 1);
    ones = 0;
    for (int i = 1; i < 36; i++) begin
      @(negedge clk);
      if (i >= 4 && bus0.txd) ones++;
    end
    chk("b2b_ff_data_ones", ones, 32);
    ren_n = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus0.fifo_r_en) ren_n++;
    end
    chk("b2b_no_third_pop", ren_n, 0);

    // Empty FIFO with tx_en high
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus0.busy || bus0.fifo_r_en) bad++;
    end
    chk("empty_gating", bad, 0);

    // tx_en dropped during the second data bit
    tick();
    bus0.tx_en = 1'b0;
    push(0, 8'h5A);
    push(0, 8'h33);
    bus0.tx_en = 1'b1;
    wait_ren(0, "drop");
    repeat (11) @(negedge clk);
    @(posedge clk);
    #2;
    bus0.tx_en = 1'b0;
    ren_n = 0; done_n = 0;
    repeat (150) begin
      @(negedge clk);
      if (bus0.fifo_r_en) ren_n++;
      if (bus0.tx_done) done_n++;
    end
    chk("drop_no_pop", ren_n, 0);
    chk("drop_frame_done", done_n, 1);
    chk("drop_idle", int'(bus0.busy), 0);

    // Asynchronous reset in the middle of a data bit of 0x33
    tick();
    bus0.tx_en = 1'b1;
    wait_ren(0, "arst");
    repeat (15) @(negedge clk);
    chk("arst_pre_txd", int'(bus0.txd), 0);
    chk("arst_pre_busy", int'(bus0.busy), 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_txd", int'(bus0.txd), 1);
    chk("arst_busy", int'(bus0.busy), 0);
    chk("arst_ren", int'(bus0.fifo_r_en), 0);
    repeat (3) tick();
    rst = 1'b0;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus0.busy || bus0.fifo_r_en) bad++;
    end
    chk("arst_stays_idle", bad, 0);

    // BAUD_DIV=2 instance, byte 0x3C
    tick();
    push(1, 8'h3C);
    bus1.tx_en = 1'b1;
    wait_ren(1, "div2");
    capture(1, 2, PAT_3C, "div2");

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Read-side consumer of the 8051 core's synchronous byte FIFO.
- Pops bytes from the FIFO read port and serialises each one as an asynchronous UART frame on txd: start bit, DATA_WIDTH data bits LSB first, optional parity bit, one stop bit.
- Sits between the SBUF-write FIFO and the serial pin, and drains the FIFO autonomously while enabled.

Parameters:
- DATA_WIDTH, 8, data bits per frame; equals FIFO data width.
- BAUD_DIV, 104, clk cycles per serial bit; legal range 2 to 2^DIV_WIDTH.
- DIV_WIDTH, 16, width of the baud counter.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- tx_en  input  1  enable; the block starts a new frame only while this is high.
- fifo_empty  input  1  FIFO empty flag.
- fifo_r_en  output  1  FIFO read strobe; a single-cycle pulse per byte.
- fifo_r_data  input  DATA_WIDTH  FIFO read data; valid the cycle after fifo_r_en is sampled high.
- txd  output  1  serial line; idle level is 1.
- busy  output  1  high whenever the state is not IDLE.
- tx_done  output  1  single-cycle pulse at the end of each stop bit.

Behaviour:
- Reset (async): state=IDLE, txd=1, fifo_r_en=0, busy=0, tx_done=0, baud counter=0, bit counter=0, shift register=0.
- A frame interrupted by reset is dropped and txd returns high immediately. The popped byte is lost.
- States: IDLE, FETCH, LOAD, START, DATA, PARITY (macro only), STOP.
- IDLE:
  - If tx_en=1 and fifo_empty=0, go to FETCH.
  - Otherwise stay in IDLE.
  - fifo_empty is sampled only in IDLE.
- FETCH: lasts one cycle. fifo_r_en=1 (decoded from the state register). Go to LOAD.
- LOAD: lasts one cycle. Shift register <= fifo_r_data; clear the baud counter; go to START.
- START: txd=0 for BAUD_DIV cycles, then go to DATA.
- DATA:
  - txd = shift register bit 0.
  - Each bit lasts BAUD_DIV cycles. At each bit end, shift right and increment the bit counter.
  - After DATA_WIDTH bits, go to STOP (or PARITY when enabled).
- STOP:
  - txd=1 for BAUD_DIV cycles.
  - On the last cycle, tx_done=1 and next state is IDLE.
- Baud counter:
  - Counts 0 to BAUD_DIV-1.
  - A bit boundary occurs when the count equals BAUD_DIV-1; the counter then wraps to 0.
- Bit counter: counts 0 to DATA_WIDTH-1 and is cleared on entry to DATA.
- txd is a flop loaded from next-state logic. Its value matches the current state in the same cycle the state is active, so it is glitch-free.
- Timing:
  - fifo_r_en to first cycle of txd=0: exactly 2 cycles.
  - Frame length: (2+DATA_WIDTH)*BAUD_DIV cycles.
  - Back-to-back frames leave 3 extra cycles of txd=1 (IDLE, FETCH, LOAD) between stop bit and next start bit.
- tx_en deasserted mid-frame: the current frame completes normally, then the block stays in IDLE.
- tx_en and fifo_empty are ignored outside IDLE.
- The block never asserts fifo_r_en while fifo_empty=1 is sampled in IDLE.
- The block never asserts fifo_r_en more than once per frame.

Optional Feature:
- Macro: FIFO_UART_TX_PARITY_EN.
- When defined:
  - PARITY state is inserted between DATA and STOP.
  - txd = XOR of the DATA_WIDTH data bits (even parity) for BAUD_DIV cycles.
  - The parity value is computed in LOAD from fifo_r_data and held in a flop.
  - Frame length becomes (3+DATA_WIDTH)*BAUD_DIV cycles.
- When undefined: no PARITY state and no parity flop; DATA goes directly to STOP.

Test Plan:
- Reset: assert rst asynchronously mid-DATA with BAUD_DIV=4 -> txd=1, busy=0, fifo_r_en=0 in the same cycle, without waiting for a clock edge. After release the block stays idle while fifo_empty=1.
- Single byte: BAUD_DIV=4, FIFO holds 0xA5, tx_en=1 ->
  - one fifo_r_en pulse;
  - txd sequence 0, 1,0,1,0,0,1,0,1, 1, each level held 4 cycles (40 cycles total);
  - tx_done pulses on cycle 40 of the frame.
- Back-to-back: FIFO holds 0x00 then 0xFF ->
  - two frames separated by exactly 3 cycles of txd=1 after the first stop bit;
  - exactly two fifo_r_en pulses;
  - second frame's data bits all 1.
- Empty/enable gating:
  - fifo_empty=1 with tx_en=1 -> no fifo_r_en, busy=0 for 100 cycles.
  - Drop tx_en during the second data bit -> frame completes, no further pop although fifo_empty=0.
- Parity (macro defined): 0xA5 -> parity bit 0; 0x07 -> parity bit 1; frame length 44 cycles at BAUD_DIV=4.
- Timing at BAUD_DIV=2: 0x3C -> each bit held 2 cycles; fifo_r_en to start bit edge is exactly 2 cycles.
